// File: rtl/seg_pkg.sv
// -----------------------------------------------------------------------------
// seg_pkg
// Shared constants for the 7-segment display chain, used by both the encoder
// and the serial frame decoder.
//   SEG_W              : bits per segment code (a..g, active-low)
//   SEG_0 .. SEG_9     : active-low segment patterns, bit6=a ... bit0=g
//   SEG_BLANK          : all segments dark
//   DIGIT_BLANK        : digit value reported for a blank code
//   DIGIT_ERR          : digit value reported for an illegal code
//   state_t            : frame decoder FSM states
// -----------------------------------------------------------------------------
package seg_pkg;

  localparam int SEG_W = 7;

  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam logic [3:0] DIGIT_ERR   = 4'hE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage : seg_pkg

// File: rtl/seg_code_to_digit.sv
// -----------------------------------------------------------------------------
// seg_code_to_digit
// Combinational map from one active-low 7-segment code back to its digit.
// Ports:
//   code  in  [6:0] segment code, bit6=a ... bit0=g, 0 = lit
//   digit out [3:0] decoded digit; DIGIT_BLANK for blank, DIGIT_ERR otherwise
//   blank out       code was all segments dark
//   err   out       code is not one of the ten digits nor blank
// -----------------------------------------------------------------------------
module seg_code_to_digit
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] code,
  output logic [3:0]       digit,
  output logic             blank,
  output logic             err
);

  // Table lookup; anything not recognised is flagged as an error.
  always_comb begin
    digit = DIGIT_ERR;
    blank = 1'b0;
    err   = 1'b0;
    case (code)
      SEG_0:     digit = 4'h0;
      SEG_1:     digit = 4'h1;
      SEG_2:     digit = 4'h2;
      SEG_3:     digit = 4'h3;
      SEG_4:     digit = 4'h4;
      SEG_5:     digit = 4'h5;
      SEG_6:     digit = 4'h6;
      SEG_7:     digit = 4'h7;
      SEG_8:     digit = 4'h8;
      SEG_9:     digit = 4'h9;
      SEG_BLANK: begin
        digit = DIGIT_BLANK;
        blank = 1'b1;
      end
      default: begin
        digit = DIGIT_ERR;
        err   = 1'b1;
      end
    endcase
  end

endmodule : seg_code_to_digit

// File: rtl/seg_frame_decoder.sv
// -----------------------------------------------------------------------------
// seg_frame_decoder
// Serial receiver for frames of NUM_DIGITS active-low 7-segment codes. Bits
// arrive MSB first per code, first code first; each complete frame is decoded
// to digits plus blank/error masks and reported with a one-cycle out_valid.
// Optional build macro: SEG_FRAME_PARITY_EN adds one trailing even-parity bit
// over all code bits; a mismatch forces every digit to DIGIT_ERR and sets
// every err_mask bit.
// Ports:
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high reset
//   in_start   in   frame-start strobe (aborts any frame in progress)
//   in_valid   in   qualifies in_bit
//   in_bit     in   serial segment bit
//   digits     out  [4*NUM_DIGITS-1:0], digit k at [4k+3:4k], k=NUM_DIGITS-1 first
//   blank_mask out  [NUM_DIGITS-1:0], code k was blank
//   err_mask   out  [NUM_DIGITS-1:0], code k was illegal
//   out_valid  out  one-cycle pulse when the outputs above update
//   busy       out  high while a frame is being shifted in
// -----------------------------------------------------------------------------
module seg_frame_decoder #(
  parameter int NUM_DIGITS = 3,
  parameter int SEG_W      = seg_pkg::SEG_W
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_start,
  input  logic                    in_valid,
  input  logic                    in_bit,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [NUM_DIGITS-1:0]   err_mask,
  output logic                    out_valid,
  output logic                    busy
);

  import seg_pkg::*;

  localparam int CODE_BITS = NUM_DIGITS * SEG_W;
`ifdef SEG_FRAME_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_BITS = CODE_BITS + PAR_BITS;
  localparam int CNT_W      = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

`ifdef SEG_FRAME_PARITY_EN
  // Even parity over the whole frame (codes + parity bit) must XOR to zero.
  function automatic logic parity_err(input logic [FRAME_BITS-1:0] f);
    return ^f;
  endfunction
`endif

  state_t                  state_r, state_next_s;
  logic [CNT_W-1:0]        cnt_r, cnt_next_s;
  logic [FRAME_BITS-1:0]   frame_r, frame_next_s;
  logic                    shift_en_s;
  logic                    load_s;

  logic [4*NUM_DIGITS-1:0] digits_r, digits_next_s;
  logic [NUM_DIGITS-1:0]   blank_r, blank_next_s;
  logic [NUM_DIGITS-1:0]   err_r, err_next_s;
  logic                    out_valid_r;
  logic                    busy_r;

  logic [3:0]              dec_digit_s [NUM_DIGITS];
  logic                    dec_blank_s [NUM_DIGITS];
  logic                    dec_err_s   [NUM_DIGITS];

  // FSM state and bit counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Next-state logic. load_s marks the edge that samples the last frame bit,
  // so the decoded outputs land together with out_valid in the DONE cycle.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    shift_en_s   = 1'b0;
    load_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_start) begin
          state_next_s = SHIFT;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = IDLE;
        end
      end
      SHIFT: begin
        if (in_start) begin
          // Abort: restart the frame, the concurrent bit is dropped.
          state_next_s = SHIFT;
          cnt_next_s   = CNT_ZERO;
        end else if (in_valid) begin
          shift_en_s = 1'b1;
          if (cnt_r == LAST_CNT) begin
            state_next_s = DONE;
            cnt_next_s   = CNT_ZERO;
            load_s       = 1'b1;
          end else begin
            cnt_next_s = cnt_r + CNT_ONE;
          end
        end else begin
          state_next_s = SHIFT;
        end
      end
      DONE: begin
        if (in_start) begin
          state_next_s = SHIFT;
          cnt_next_s   = CNT_ZERO;
        end else begin
          state_next_s = IDLE;
        end
      end
      default: begin
        state_next_s = IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // Frame shift register contents after this edge.
  always_comb begin
    if (shift_en_s) begin
      frame_next_s = {frame_r[FRAME_BITS-2:0], in_bit};
    end else begin
      frame_next_s = frame_r;
    end
  end

  // Frame shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_r <= {FRAME_BITS{1'b1}};
    end else begin
      frame_r <= frame_next_s;
    end
  end

  // Decode from the post-shift frame so the final bit is included on load.
  // First received code sits in the top bits, i.e. code index NUM_DIGITS-1.
  for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_dec
    seg_code_to_digit u_dec (
      .code  (frame_next_s[PAR_BITS + SEG_W*k +: SEG_W]),
      .digit (dec_digit_s[k]),
      .blank (dec_blank_s[k]),
      .err   (dec_err_s[k])
    );
  end

  // Pack per-code results; a parity failure overrides every code.
  always_comb begin
    digits_next_s = {NUM_DIGITS{DIGIT_ERR}};
    blank_next_s  = {NUM_DIGITS{1'b0}};
    err_next_s    = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      digits_next_s[4*k +: 4] = dec_digit_s[k];
      blank_next_s[k]         = dec_blank_s[k];
      err_next_s[k]           = dec_err_s[k];
    end
`ifdef SEG_FRAME_PARITY_EN
    if (parity_err(frame_next_s)) begin
      digits_next_s = {NUM_DIGITS{DIGIT_ERR}};
      blank_next_s  = {NUM_DIGITS{1'b0}};
      err_next_s    = {NUM_DIGITS{1'b1}};
    end else begin
      err_next_s    = err_next_s;
    end
`endif
  end

  // Output registers; decoded values hold between frames.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_r    <= {NUM_DIGITS{DIGIT_BLANK}};
      blank_r     <= {NUM_DIGITS{1'b1}};
      err_r       <= {NUM_DIGITS{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= load_s;
      busy_r      <= (state_next_s == SHIFT);
      if (load_s) begin
        digits_r <= digits_next_s;
        blank_r  <= blank_next_s;
        err_r    <= err_next_s;
      end else begin
        digits_r <= digits_r;
        blank_r  <= blank_r;
        err_r    <= err_r;
      end
    end
  end

  assign digits     = digits_r;
  assign blank_mask = blank_r;
  assign err_mask   = err_r;
  assign out_valid  = out_valid_r;
  assign busy       = busy_r;

endmodule : seg_frame_decoder
